// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative radix-2 multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock; sign handled by magnitude + fixup.
`default_nettype none

module sm_muldiv #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             cancel,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t             state_q;
   logic               is_div_q;
   logic               neg_q_q;
   logic               neg_r_q;
   logic [WIDTH-1:0]   opb_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      cnt_q;

   // Launch decode
   logic               signed_op;
   logic               a_neg_d;
   logic               b_neg_d;
   logic [WIDTH-1:0]   a_mag_d;
   logic [WIDTH-1:0]   b_mag_d;

   // Iteration datapath
   logic [WIDTH:0]     mul_sum_d;
   logic [WIDTH:0]     div_trial_d;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   res_hi_d;
   logic [WIDTH-1:0]   res_lo_d;

   always_comb begin
      signed_op = SIGNED_EN && oper[0];
      a_neg_d   = signed_op && srcA[WIDTH-1];
      b_neg_d   = signed_op && srcB[WIDTH-1];
      a_mag_d   = a_neg_d ? -srcA : srcA;
      b_mag_d   = b_neg_d ? -srcB : srcB;
   end

   always_comb begin
      mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_trial_d = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
      if (!is_div_q)
         acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
      else if (div_trial_d[WIDTH])
         acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else
         acc_d = {div_trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_d = neg_q_q ? -acc_d : acc_d;
      if (is_div_q) begin
         res_lo_d = neg_q_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
         res_hi_d = neg_r_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
      end else begin
         res_lo_d = prod_d[WIDTH-1:0];
         res_hi_d = prod_d[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hiWrite) hi <= wd;
               if (loWrite) lo <= wd;
               if (start) begin
                  state_q  <= CALC;
                  busy     <= 1'b1;
                  cnt_q    <= CW'(WIDTH);
                  is_div_q <= oper[1];
                  // A zero divisor keeps the all-ones quotient un-negated.
                  neg_q_q  <= (a_neg_d ^ b_neg_d) && !(oper[1] && (srcB == '0));
                  neg_r_q  <= oper[1] && a_neg_d;
                  if (oper[1]) begin
                     acc_q <= {{WIDTH{1'b0}}, a_mag_d};
                     opb_q <= b_mag_d;
                  end else begin
                     acc_q <= {{WIDTH{1'b0}}, b_mag_d};
                     opb_q <= a_mag_d;
                  end
               end
            end
            CALC: begin
               if (cancel) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_q <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     hi      <= res_hi_d;
                     lo      <= res_lo_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sm_muldiv.sv
// Directed testbench for sm_muldiv (WIDTH=32), signed and unsigned-only instances.
`default_nettype none

module tb_sm_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  oper = 2'b00;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        cancel = 1'b0;
   logic        hiWrite = 1'b0;
   logic        loWrite = 1'b0;
   logic [31:0] wd = '0;
   logic        busy, done, busy_u, done_u;
   logic [31:0] hi, lo, hi_u, lo_u;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
      .cancel(cancel), .hiWrite(hiWrite), .loWrite(loWrite), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_u (
      .clk(clk), .rst(rst), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
      .cancel(cancel), .hiWrite(hiWrite), .loWrite(loWrite), .wd(wd),
      .busy(busy_u), .done(done_u), .hi(hi_u), .lo(lo_u)
   );

   // Launch an op and wait (bounded) for done; lat = edges after start edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; oper = op; srcA = a; srcB = b;
      @(posedge clk); #1;
      start = 1'b0;
      bcnt = busy ? 1 : 0;
      lat  = 0;
      while (lat < 40 && !done) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_multu();
      int lat, bcnt;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL multu_latency got %0d want 32", lat); end
      n_cmp++; if (bcnt !== 32) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 32", bcnt); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
   endtask

   task automatic test_mult_signed();
      int lat, bcnt;
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
      n_cmp++; if (hi_u !== 32'h0000_0006) begin n_err++; $display("FAIL mult_nosign_hi got %h want 00000006", hi_u); end
      n_cmp++; if (lo_u !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_nosign_lo got %h want ffffffeb", lo_u); end
   endtask

   task automatic test_div();
      int lat, bcnt;
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL div_latency got %0d want 32", lat); end
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
      run_op(2'b10, 32'd100, 32'd7, lat, bcnt);
      n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %0d want 14", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %0d want 2", hi); end
   endtask

   task automatic test_div_corner();
      int lat, bcnt;
      run_op(2'b10, 32'd5, 32'd0, lat, bcnt);
      n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL divz_latency got %0d want 32", lat); end
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divuz_lo got %h want ffffffff", lo); end
      n_cmp++; if (hi !== 32'd5) begin n_err++; $display("FAIL divuz_hi got %h want 00000005", hi); end
      run_op(2'b11, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_signed_lo got %h want ffffffff", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL divz_signed_hi got %h want fffffffb", hi); end
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi got %h want 0", hi); end
   endtask

   task automatic test_mthi_cancel();
      int ndone;
      @(negedge clk); hiWrite = 1'b1; wd = 32'h1234;
      @(posedge clk); #1; hiWrite = 1'b0;
      n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi got %h want 00001234", hi); end
      // MULTU 2x3 with an ignored second start and ignored MTLO mid-op
      @(negedge clk); start = 1'b1; oper = 2'b00; srcA = 32'd2; srcB = 32'd3;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; srcA = 32'd5; srcB = 32'd5; loWrite = 1'b1; wd = 32'hDEAD;
      @(negedge clk); start = 1'b0; loWrite = 1'b0;
      ndone = 0;
      repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
      n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL start_ignored_done_count got %0d want 1", ndone); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL multu_small_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL multu_small_lo got %h want 6", lo); end
      // Cancel at iteration edge 10
      @(negedge clk); start = 1'b1; oper = 2'b00; srcA = 32'd7; srcB = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy got %b want 0", busy); end
      ndone = 0;
      repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
      n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL cancel_done_count got %0d want 0", ndone); end
      n_cmp++; if (lo !== 32'd6 || hi !== 32'h0) begin n_err++; $display("FAIL cancel_hilo got %h_%h want 00000000_00000006", hi, lo); end
      // Cancel coinciding with the final iteration edge
      @(negedge clk); start = 1'b1; oper = 2'b00; srcA = 32'd3; srcB = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      repeat (31) @(posedge clk);
      @(negedge clk); cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cancel_final_done got %b want 0", done); end
      n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL cancel_final_lo got %h want 6", lo); end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      @(negedge clk); start = 1'b1; oper = 2'b11; srcA = 32'd1000; srcB = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
      n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL midrst_hilo got %h_%h want 0_0", hi, lo); end
      @(negedge clk); rst = 1'b0;
      run_op(2'b10, 32'd9, 32'd4, lat, bcnt);
      n_cmp++; if (lo !== 32'd2) begin n_err++; $display("FAIL post_rst_divu_lo got %0d want 2", lo); end
      n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL post_rst_divu_hi got %0d want 1", hi); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_multu();
      test_mult_signed();
      test_div();
      test_div_corner();
      test_mthi_cancel();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
